mat_vec_loader: RTL and testbench

//  Front-end sequencer that drives the 8x8 matrix-vector multiplier. Accepts a byte stream
//  (valid/ready): 64 bytes of A in row-major order, then 8 bytes of B. Steers each byte into
//  the multiplier's A-row FIFOs or B FIFO and pulses Clr before each job. Waits for the

---
 rtl/mat_vec_loader.sv | 170 +++++++++++++++++
 tb/tb_mat_vec_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_loader.sv
`default_nettype none
// ============================================================================
// mat_vec_loader : steers a byte stream into the 8x8 multiplier FIFOs and
//                  returns the eight results as a valid/ready stream.
// Revision       : 1.0
// ============================================================================
module mat_vec_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          err,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DIM-1:0]                a_wren,
  output logic                          b_wren,
  output logic [DATA_WIDTH-1:0]         a_fifo_in,
  output logic [DATA_WIDTH-1:0]         b_fifo_in,
  output logic                          mv_clr,
  input  logic                          mv_done,
  input  logic [DIM*3*DATA_WIDTH-1:0]   mv_out,
  output logic [3*DATA_WIDTH-1:0]       res_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [2:0]                    res_idx,
  output logic                          res_last
);

  localparam int RW = 3 * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_cnt;
  logic [TW-1:0]   r_tmo;
  logic            r_done_d;
  logic [2:0]      r_idx;
  logic [RW-1:0]   r_buf [DIM];
  logic [RW-1:0]   w_row [DIM];
  logic            w_hs;
  logic            w_rise;
  logic            w_tmo_hit;
  logic            w_res_hs;

  genvar g;
  generate
    for (g = 0; g < DIM; g++) begin : g_row
      assign w_row[g] = mv_out[g*RW +: RW];
    end
  endgenerate

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign mv_clr    = (r_state == S_CLEAR);
  assign res_valid = (r_state == S_DRAIN);
  assign res_data  = res_valid ? r_buf[r_idx] : '0;
  assign res_idx   = res_valid ? r_idx : 3'd0;
  assign res_last  = res_valid && (r_idx == 3'd7);

  assign w_hs      = in_valid & in_ready;
  // Only a fresh rising edge counts; a done level left over from the last job is ignored.
  assign w_rise    = mv_done & ~r_done_d;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT));
  assign w_res_hs  = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_LOAD_A;
      S_LOAD_A: if (w_hs && (r_cnt == 6'd63)) w_next = S_LOAD_B;
      S_LOAD_B: if (w_hs && (r_cnt == 6'd7)) w_next = S_WAIT;
      S_WAIT: begin
        if (w_rise) begin
          w_next = S_DRAIN;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN:  if (w_res_hs && (r_idx == 3'd7)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      a_wren    <= '0;
      b_wren    <= 1'b0;
      a_fifo_in <= '0;
      b_fifo_in <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_done_d  <= 1'b0;
      r_idx     <= '0;
      for (int i = 0; i < DIM; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      a_wren   <= '0;
      b_wren   <= 1'b0;
      r_done_d <= mv_done;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            err   <= 1'b0;
            r_cnt <= '0;
            r_idx <= '0;
          end
        end
        S_LOAD_A: begin
          if (w_hs) begin
            // Row-major stream: bits [5:3] of the byte count select the A row.
            a_wren    <= DIM'(1) << r_cnt[5:3];
            a_fifo_in <= in_data;
            r_cnt     <= r_cnt + 6'd1;
          end
        end
        S_LOAD_B: begin
          if (w_hs) begin
            b_wren    <= 1'b1;
            b_fifo_in <= in_data;
            r_cnt     <= r_cnt + 6'd1;
            r_tmo     <= '0;
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            for (int i = 0; i < DIM; i++) begin
              r_buf[i] <= w_row[i];
            end
          end else if (w_tmo_hit) begin
            err <= 1'b1;
          end
          r_tmo <= r_tmo + TW'(1);
        end
        S_DRAIN: begin
          if (w_res_hs) begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_vec_loader.sv
`default_nettype none
// tb_mat_vec_loader: emulates the multiplier FIFOs and compares the result stream
// with a matrix-vector product of the randomized bytes sent.
module tb_mat_vec_loader;

  localparam int DW  = 8;
  localparam int DIM = 8;
  localparam int RW  = 3 * DW;
  localparam int TO  = 15;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic              busy;
  logic              err;
  logic [DW-1:0]     in_data   = '0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DIM-1:0]    a_wren;
  logic              b_wren;
  logic [DW-1:0]     a_fifo_in;
  logic [DW-1:0]     b_fifo_in;
  logic              mv_clr;
  logic              mv_done   = 1'b0;
  logic [DIM*RW-1:0] mv_out    = '0;
  logic [RW-1:0]     res_data;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [2:0]        res_idx;
  logic              res_last;

  always #5 clk = ~clk;

  mat_vec_loader #(.DATA_WIDTH(DW), .DIM(DIM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a_wren(a_wren), .b_wren(b_wren), .a_fifo_in(a_fifo_in), .b_fifo_in(b_fifo_in),
    .mv_clr(mv_clr), .mv_done(mv_done), .mv_out(mv_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_last(res_last)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mon_row;

  int         hs_cyc[$];
  int         a_row[$];
  logic [7:0] a_dat[$];
  int         a_cyc[$];
  logic [7:0] b_dat[$];
  int         b_cyc[$];
  int         clr_cyc[$];

  logic [7:0]    mat[64];
  logic [7:0]    vec[8];
  logic [RW-1:0] expv[8];

  // Edge monitor: values read here are the ones present just before the edge.
  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) hs_cyc.push_back(cyc);
    if (mv_clr) clr_cyc.push_back(cyc);
    if (b_wren) begin
      b_dat.push_back(b_fifo_in);
      b_cyc.push_back(cyc);
    end
    if (a_wren != '0) begin
      mon_row = -1;
      for (int i = 0; i < DIM; i++) if (a_wren == (8'd1 << i)) mon_row = i;
      a_row.push_back(mon_row);
      a_dat.push_back(a_fifo_in);
      a_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model();
    int s;
    for (int r = 0; r < 8; r++) begin
      s = 0;
      for (int j = 0; j < 8; j++) s += int'(mat[r*8+j]) * int'(vec[j]);
      expv[r] = RW'(s);
    end
  endfunction

  task automatic rand_fill();
    for (int i = 0; i < 64; i++) mat[i] = 8'($urandom);
    for (int j = 0; j < 8; j++)  vec[j] = 8'($urandom);
  endtask

  // Multiplier stand-in: the i-th write to a row is column i; computed from what was written.
  task automatic emu_compute();
    int         cnt[8];
    logic [7:0] ea[8][8];
    int         s;
    for (int r = 0; r < 8; r++) begin
      cnt[r] = 0;
      for (int j = 0; j < 8; j++) ea[r][j] = '0;
    end
    for (int i = 0; i < a_row.size(); i++) begin
      if (a_row[i] >= 0 && cnt[a_row[i]] < 8) begin
        ea[a_row[i]][cnt[a_row[i]]] = a_dat[i];
        cnt[a_row[i]]++;
      end
    end
    for (int r = 0; r < 8; r++) begin
      s = 0;
      for (int j = 0; j < 8; j++) if (j < b_dat.size()) s += int'(ea[r][j]) * int'(b_dat[j]);
      mv_out[r*RW +: RW] = RW'(s);
    end
  endtask

  task automatic begin_job(input bit hold_done);
    hs_cyc.delete(); a_row.delete(); a_dat.delete(); a_cyc.delete();
    b_dat.delete(); b_cyc.delete(); clr_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clr", err, 0);
    chk("clr_pulse", mv_clr, 1);
    if (!hold_done) mv_done = 1'b0;
  endtask

  task automatic feed(input int vmode, input bit start_in_b, input int rst_at, output bit aborted);
    int k;
    int budget;
    k = 0; budget = 0; aborted = 1'b0;
    while (k < 72) begin
      @(negedge clk);
      start = 1'b0;
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_busy", busy, 0);       chk("rst_in_ready", in_ready, 0);
        chk("rst_a_wren", a_wren, 0);   chk("rst_a_fifo_in", a_fifo_in, 0);
        chk("rst_b_fifo_in", b_fifo_in, 0); chk("rst_mv_clr", mv_clr, 0);
        chk("rst_res_valid", res_valid, 0); chk("rst_err", err, 0);
        aborted = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~in_valid;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = (k < 64) ? mat[k] : vec[k-64];
      if (start_in_b && k >= 66 && k < 70) start = 1'b1;
      if (in_valid && in_ready) k++;
      budget++;
      if (budget > 2000) begin
        chk("feed_budget", k, 72);
        aborted = 1'b1;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic give_done();
    int w;
    w = 0;
    while (b_cyc.size() < 8 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("b_wren_count", b_cyc.size(), 8);
    @(negedge clk);
    emu_compute();
    mv_done = 1'b1;
  endtask

  task automatic check_loads();
    chk("clr_count", clr_cyc.size(), 1);
    chk("a_wren_count", a_row.size(), 64);
    chk("hs_count", hs_cyc.size(), 72);
    if (clr_cyc.size() > 0 && a_cyc.size() > 0) chk("clr_before_a", clr_cyc[0] < a_cyc[0], 1);
    for (int i = 0; i < 64 && i < a_row.size(); i++) begin
      chk("a_row", a_row[i], i / 8);
      chk("a_data", a_dat[i], mat[i]);
      if (i < hs_cyc.size()) chk("a_latency", a_cyc[i] - hs_cyc[i], 1);
    end
    for (int j = 0; j < 8 && j < b_dat.size(); j++) begin
      chk("b_data", b_dat[j], vec[j]);
      if (64 + j < hs_cyc.size()) chk("b_latency", b_cyc[j] - hs_cyc[64+j], 1);
    end
  endtask

  task automatic drain(input int rmode, input int stall_idx);
    int n, w, st;
    n = 0; w = 0; st = 0;
    while (n < 8 && w < 400) begin
      @(negedge clk);
      w++;
      if (res_valid) begin
        chk("res_data", res_data, expv[n]);
        chk("res_idx", res_idx, n);
        chk("res_last", res_last, n == 7);
        if (n == stall_idx && st < 5) begin
          res_ready = 1'b0;
          st++;
        end else if (rmode != 0) begin
          res_ready = 1'($urandom_range(0, 1));
        end else begin
          res_ready = 1'b1;
        end
        if (res_ready) n++;
      end
    end
    chk("drain_count", n, 8);
    @(negedge clk);
    chk("busy_after_drain", busy, 0);
    chk("valid_after_drain", res_valid, 0);
    res_ready = 1'b0;
  endtask

  task automatic expect_timeout();
    int e;
    if (hs_cyc.size() != 72) begin
      chk("to_hs_count", hs_cyc.size(), 72);
      return;
    end
    e = hs_cyc[71];
    while (cyc < e + TO) @(negedge clk);
    chk("to_busy_before", busy, 1);
    chk("to_err_before", err, 0);
    @(negedge clk);
    chk("to_busy_after", busy, 0);
    chk("to_err_after", err, 1);
    chk("to_no_result", res_valid, 0);
  endtask

  task automatic run_job(input int vmode, input int rmode, input int stall, input bit startb);
    bit ab;
    model();
    begin_job(1'b0);
    feed(vmode, startb, -1, ab);
    give_done();
    check_loads();
    drain(rmode, stall);
  endtask

  initial begin
    bit ab;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);        chk("reset_err", err, 0);
    chk("reset_in_ready", in_ready, 0); chk("reset_a_wren", a_wren, 0);
    chk("reset_b_wren", b_wren, 0);    chk("reset_mv_clr", mv_clr, 0);
    chk("reset_res_valid", res_valid, 0); chk("reset_res_data", res_data, 0);
    chk("reset_res_last", res_last, 0);
    rst_n = 1'b1;

    // identity matrix, B = 1..8
    for (int i = 0; i < 64; i++) mat[i] = (i / 8 == i % 8) ? 8'd1 : 8'd0;
    for (int j = 0; j < 8; j++)  vec[j] = 8'(j + 1);
    run_job(0, 0, -1, 1'b0);

    // saturated inputs: every row sums to 8*255*255
    for (int i = 0; i < 64; i++) mat[i] = 8'hFF;
    for (int j = 0; j < 8; j++)  vec[j] = 8'hFF;
    run_job(0, 0, -1, 1'b0);

    rand_fill(); run_job(1, 0, -1, 1'b0);   // toggling in_valid
    rand_fill(); run_job(0, 0, 3, 1'b0);    // 5-cycle stall at idx 3
    rand_fill(); run_job(2, 1, -1, 1'b0);   // random valid and ready

    // mv_done never rises: timeout, then the next start clears err
    rand_fill(); begin_job(1'b0); feed(0, 1'b0, -1, ab); expect_timeout();
    rand_fill(); run_job(2, 0, -1, 1'b0);

    // mv_done still high from the previous job must not trigger
    rand_fill(); begin_job(1'b1); feed(0, 1'b0, -1, ab); expect_timeout();

    // reset after 20 A bytes, then a fresh job with start pulsed during LOAD_B
    rand_fill(); begin_job(1'b0); feed(0, 1'b0, 20, ab);
    rand_fill(); run_job(0, 0, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
